// File: rtl/l1a_davact_buf_pkg.sv
// ---------------------------------------------------------------------------
// l1a_davact_buf_pkg
// Shared constants and types for the L1A data-available activity buffer.
//   DAV_W       : width of the per-source data-available vector (17 sources)
//   MISS_W      : width of the saturating dropped-L1A counter
//   MISS_MAX    : saturation value of that counter
//   win_state_e : match-window FSM state encoding
// ---------------------------------------------------------------------------
package l1a_davact_buf_pkg;

    localparam int DAV_W  = 17;
    localparam int MISS_W = 8;

    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } win_state_e;

endpackage

// File: rtl/l1a_davact_buf_fifo.sv
// ---------------------------------------------------------------------------
// davact_fifo
// Circular-buffer FIFO of DAV vectors with first-word fall-through head.
//   clk     : clock
//   clr     : synchronous clear (pointers, count, overflow flag)
//   wr_req  : write request, wr_data is stored when there is room
//   wr_data : DAV vector to store
//   pop_req : advance the read pointer (ignored while empty)
//   head    : oldest stored entry, 0 while empty
//   empty   : no entries held
//   full    : count equals DEPTH
//   ovfl    : sticky, a write was refused because the FIFO was full
// ---------------------------------------------------------------------------
module davact_fifo
    import l1a_davact_buf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_req,
    input  logic [DAV_W-1:0] wr_data,
    input  logic             pop_req,
    output logic [DAV_W-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             ovfl
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovfl_q, ovfl_d;
    logic [DAV_W-1:0] mem_q [DEPTH];

    logic do_pop;
    logic do_write;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign ovfl  = ovfl_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // write when it is popped at the same time.
    assign do_pop   = pop_req && !empty;
    assign do_write = wr_req && (!full || do_pop);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovfl_d   = ovfl_q | (wr_req & full & ~do_pop);

        // DEPTH is a power of two, so pointers wrap by plain overflow.
        if (do_write) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({do_write, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovfl_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovfl_q   <= ovfl_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the head is masked
    // while empty, so stale words are never observable.
    always_ff @(posedge clk) begin
        if (do_write && !clr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign head = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/l1a_davact_buf.sv
// ---------------------------------------------------------------------------
// l1a_davact_buf
// Collects masked data-available pulses over a match window opened by each
// accepted L1A and queues one DAV vector per accepted L1A.
//   CLKCMS   : 40 MHz CMS clock
//   RST      : synchronous active-high reset
//   L1ARST   : synchronous functional clear (FIFO, window, OVFL, L1AMISS)
//   L1A      : accepted-trigger pulse
//   WINDOW   : match window length minus one, in cycles
//   DAVIN    : per-source data-available pulses
//   DAVMASK  : per-source enable
//   POPBRAM  : pop request from the control stage
//   GEMPTY_B : FIFO holds at least one entry
//   DAVACT   : head-of-FIFO entry (first-word fall-through)
//   FULL     : FIFO full
//   OVFL     : sticky, a write was attempted while full
//   L1AMISS  : saturating count of L1As dropped while a window was open
// ---------------------------------------------------------------------------
module l1a_davact_buf
    import l1a_davact_buf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              CLKCMS,
    input  logic              RST,
    input  logic              L1ARST,
    input  logic              L1A,
    input  logic [3:0]        WINDOW,
    input  logic [DAV_W-1:0]  DAVIN,
    input  logic [DAV_W-1:0]  DAVMASK,
    input  logic              POPBRAM,
    output logic              GEMPTY_B,
    output logic [DAV_W-1:0]  DAVACT,
    output logic              FULL,
    output logic              OVFL,
    output logic [MISS_W-1:0] L1AMISS
);

    win_state_e        state_q, state_d;
    logic [3:0]        win_cnt_q, win_cnt_d;
    logic [DAV_W-1:0]  acc_q, acc_d;
    logic [MISS_W-1:0] miss_q, miss_d;

    logic              clr;
    logic [DAV_W-1:0]  dav_m;
    logic              wr_req;
    logic [DAV_W-1:0]  wr_data;
    logic [DAV_W-1:0]  fifo_head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_ovfl;

    assign clr   = RST | L1ARST;
    assign dav_m = DAVIN & DAVMASK;

    // win_cnt counts the window cycles still to come after the current one,
    // so the write lands on the edge that ends cycle t+WINDOW and includes
    // that cycle's DAVIN. WINDOW=0 therefore writes straight from IDLE.
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        acc_d     = acc_q;
        miss_d    = miss_q;
        wr_req    = 1'b0;
        wr_data   = acc_q | dav_m;

        unique case (state_q)
            ST_IDLE: begin
                if (L1A) begin
                    acc_d   = dav_m;
                    wr_data = dav_m;
                    if (WINDOW == 4'd0) begin
                        wr_req = 1'b1;
                        acc_d  = '0;
                    end else begin
                        state_d   = ST_OPEN;
                        win_cnt_d = WINDOW - 4'd1;
                    end
                end
            end
            ST_OPEN: begin
                acc_d = acc_q | dav_m;
                if (L1A && (miss_q != MISS_MAX)) miss_d = miss_q + MISS_W'(1);
                if (win_cnt_q == 4'd0) begin
                    wr_req  = 1'b1;
                    state_d = ST_IDLE;
                    acc_d   = '0;
                end else begin
                    win_cnt_d = win_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLKCMS) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            win_cnt_q <= '0;
            acc_q     <= '0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            acc_q     <= acc_d;
            miss_q    <= miss_d;
        end
    end

    davact_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLKCMS),
        .clr     (clr),
        .wr_req  (wr_req),
        .wr_data (wr_data),
        .pop_req (POPBRAM),
        .head    (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .ovfl    (fifo_ovfl)
    );

    // Outputs read as zero for the whole time a clear is asserted, not only
    // from the edge after it.
    assign GEMPTY_B = ~fifo_empty & ~clr;
    assign DAVACT   = clr ? '0 : fifo_head;
    assign FULL     = fifo_full & ~clr;
    assign OVFL     = fifo_ovfl & ~clr;
    assign L1AMISS  = clr ? '0 : miss_q;

endmodule

// File: tb/tb_l1a_davact_buf.sv
module tb_l1a_davact_buf;
    import l1a_davact_buf_pkg::*;

    localparam int DEPTH = 8;

    logic              CLKCMS = 1'b0;
    logic              RST = 1'b1;
    logic              L1ARST = 1'b0;
    logic              L1A = 1'b0;
    logic [3:0]        WINDOW = 4'd0;
    logic [DAV_W-1:0]  DAVIN = '0;
    logic [DAV_W-1:0]  DAVMASK = '1;
    logic              POPBRAM = 1'b0;
    logic              GEMPTY_B;
    logic [DAV_W-1:0]  DAVACT;
    logic              FULL;
    logic              OVFL;
    logic [MISS_W-1:0] L1AMISS;

    always #5 CLKCMS = ~CLKCMS;

    l1a_davact_buf #(.DEPTH(DEPTH)) dut (
        .CLKCMS   (CLKCMS),
        .RST      (RST),
        .L1ARST   (L1ARST),
        .L1A      (L1A),
        .WINDOW   (WINDOW),
        .DAVIN    (DAVIN),
        .DAVMASK  (DAVMASK),
        .POPBRAM  (POPBRAM),
        .GEMPTY_B (GEMPTY_B),
        .DAVACT   (DAVACT),
        .FULL     (FULL),
        .OVFL     (OVFL),
        .L1AMISS  (L1AMISS)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: window described by its absolute end cycle, FIFO as a queue.
    int               cyc = 0;
    bit               m_open = 0;
    int               m_end = 0;
    logic [DAV_W-1:0] m_acc = '0;
    logic [DAV_W-1:0] m_q[$];
    bit               m_ovfl = 0;
    int               m_miss = 0;
    bit               m_zero = 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        bit               wr;
        bit               popped;
        logic [DAV_W-1:0] wdata;
        logic [DAV_W-1:0] dm;
        dm    = DAVIN & DAVMASK;
        wr    = 0;
        wdata = '0;
        if (RST || L1ARST) begin
            m_q.delete();
            m_open = 0;
            m_ovfl = 0;
            m_miss = 0;
            m_zero = 1;
        end else begin
            if (m_open) begin
                m_acc = m_acc | dm;
                if (L1A) m_miss = (m_miss < 255) ? m_miss + 1 : 255;
                if (cyc == m_end) begin
                    wr     = 1;
                    wdata  = m_acc;
                    m_open = 0;
                end
            end else if (L1A) begin
                m_acc = dm;
                if (WINDOW == 0) begin
                    wr    = 1;
                    wdata = dm;
                end else begin
                    m_open = 1;
                    m_end  = cyc + int'(WINDOW);
                end
            end
            popped = POPBRAM && (m_q.size() > 0);
            if (popped) void'(m_q.pop_front());
            if (wr) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(wdata);
                    m_zero = 0;
                end else begin
                    m_ovfl = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("gempty_b", 32'(GEMPTY_B), 32'(m_q.size() > 0));
        check("full", 32'(FULL), 32'(m_q.size() == DEPTH));
        check("ovfl", 32'(OVFL), 32'(m_ovfl));
        check("l1amiss", 32'(L1AMISS), 32'(m_miss));
        if (m_q.size() > 0)
            check("davact", 32'(DAVACT), 32'(m_q[0]));
        else if (m_zero)
            check("davact_zero", 32'(DAVACT), 32'd0);
    endtask

    // One clock cycle: inputs already driven belong to this cycle; outputs
    // are compared 1 time unit after the edge that ends it.
    task automatic step();
        @(posedge CLKCMS);
        model_update();
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic tick(input bit l1a_i, input logic [DAV_W-1:0] dav_i, input bit pop_i);
        L1A     = l1a_i;
        DAVIN   = dav_i;
        POPBRAM = pop_i;
        step();
        L1A     = 1'b0;
        DAVIN   = '0;
        POPBRAM = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(0, '0, 0);
        tick(0, '0, 0);
        RST = 1'b0;
    endtask

    initial begin
        int pop_pct;

        // Reset state, plus a pop while empty must leave DAVACT at 0.
        DAVMASK = '1;
        do_reset();
        check("rst_gempty_b", 32'(GEMPTY_B), 32'd0);
        check("rst_davact", 32'(DAVACT), 32'd0);
        check("rst_l1amiss", 32'(L1AMISS), 32'd0);
        tick(0, '0, 1);
        check("pop_empty_davact", 32'(DAVACT), 32'd0);

        // WINDOW=3, L1A in cycle 10, DAVIN=2 in cycle 12 -> visible in cycle 14.
        do_reset();
        WINDOW = 4'd3;
        for (int i = 0; i < 10; i++) tick(0, '0, 0);
        tick(1, '0, 0);
        tick(0, '0, 0);
        tick(0, 17'h00002, 0);
        check("a_cyc13_gempty_b", 32'(GEMPTY_B), 32'd0);
        tick(0, '0, 0);
        check("a_cyc14_gempty_b", 32'(GEMPTY_B), 32'd1);
        check("a_cyc14_davact", 32'(DAVACT), 32'h00002);

        // L1As at 10 and 12 -> one entry, one miss; L1A at 14 written end of 17.
        do_reset();
        WINDOW = 4'd3;
        for (int i = 0; i < 10; i++) tick(0, '0, 0);
        tick(1, '0, 0);
        tick(0, '0, 0);
        tick(1, 17'h00004, 0);
        check("b_l1amiss", 32'(L1AMISS), 32'd1);
        tick(0, '0, 0);
        check("b_first_entry", 32'(DAVACT), 32'h00004);
        tick(1, '0, 0);
        tick(0, 17'h00010, 0);
        tick(0, '0, 1);
        check("b_cyc17_gempty_b", 32'(GEMPTY_B), 32'd0);
        tick(0, '0, 0);
        check("b_cyc18_gempty_b", 32'(GEMPTY_B), 32'd1);
        check("b_second_entry", 32'(DAVACT), 32'h00010);

        // Nine windows without pops: FULL after 8, OVFL after 9, order kept.
        do_reset();
        WINDOW = 4'd1;
        for (int k = 1; k <= 9; k++) begin
            tick(1, DAV_W'(k), 0);
            tick(0, '0, 0);
            tick(0, '0, 0);
            if (k == 8) begin
                check("c_full_after8", 32'(FULL), 32'd1);
                check("c_ovfl_after8", 32'(OVFL), 32'd0);
            end
        end
        check("c_ovfl_after9", 32'(OVFL), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            check("c_pop_order", 32'(DAVACT), 32'(k));
            tick(0, '0, 1);
        end
        check("c_drained", 32'(GEMPTY_B), 32'd0);

        // L1ARST clears OVFL; then write and pop together while full.
        L1ARST = 1'b1;
        tick(0, '0, 0);
        L1ARST = 1'b0;
        check("l1arst_ovfl", 32'(OVFL), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick(1, DAV_W'(17'h100 + k), 0);
            tick(0, '0, 0);
        end
        check("d_full", 32'(FULL), 32'd1);
        tick(1, 17'h1AAAA, 0);
        tick(0, '0, 1);
        tick(0, '0, 0);
        check("d_full_kept", 32'(FULL), 32'd1);
        check("d_ovfl_kept", 32'(OVFL), 32'd0);
        for (int k = 2; k <= 8; k++) begin
            check("d_pop_order", 32'(DAVACT), 32'(17'h100 + k));
            tick(0, '0, 1);
        end
        check("d_new_last", 32'(DAVACT), 32'h1AAAA);

        // Mask removes source 1.
        do_reset();
        WINDOW  = 4'd0;
        DAVMASK = 17'h1FFFD;
        tick(1, 17'h00003, 0);
        check("mask_davact", 32'(DAVACT), 32'h00001);
        DAVMASK = '1;

        // RST in cycle t+2 of a WINDOW=5 window: no entry, next L1A accepted.
        do_reset();
        WINDOW = 4'd5;
        tick(1, 17'h000FF, 0);
        tick(0, 17'h00F00, 0);
        RST = 1'b1;
        tick(0, '0, 0);
        RST = 1'b0;
        for (int i = 0; i < 8; i++) tick(0, '0, 0);
        check("e_no_entry", 32'(GEMPTY_B), 32'd0);
        WINDOW = 4'd0;
        tick(1, 17'h00007, 0);
        check("e_next_accepted", 32'(GEMPTY_B), 32'd1);
        check("e_next_davact", 32'(DAVACT), 32'h00007);

        // Randomised traffic against the model; WINDOW only changes while idle.
        do_reset();
        pop_pct = 40;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) pop_pct = $urandom_range(5, 80);
            if (!m_open && $urandom_range(0, 9) == 0) WINDOW = 4'($urandom_range(0, 15));
            DAVMASK = ($urandom_range(0, 3) == 0) ? DAV_W'($urandom) : '1;
            RST     = ($urandom_range(0, 599) == 0);
            L1ARST  = ($urandom_range(0, 399) == 0);
            tick($urandom_range(0, 3) == 0, DAV_W'($urandom),
                 $urandom_range(0, 99) < pop_pct);
            RST    = 1'b0;
            L1ARST = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
